intxn_ctrl: RTL and testbench
=============================

INTXN_CTRL -- requirements
Module: intxn_ctrl

Interface
REQ-001 Parameter CYCLES_PER_TICK, default 50000, clock cycles per timing tick (1 ms at 50 MHz).
REQ-002 Parameter NS_MIN_GREEN, default 10000, minimum north/south green in ticks.
REQ-003 Parameter YELLOW, default 3000, yellow duration in ticks, both directions.
REQ-004 Parameter ALL_RED, default 1000, all-red clearance duration in ticks.
REQ-005 Parameter EW_GREEN, default 5000, east/west green duration in ticks.
REQ-006 clock  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 car_detected  input  1  asynchronous east/west vehicle sensor, active high.
REQ-009 lights_out  output  6  registered lamp drive: [5:3]=N/S {R,Y,G}, [2:0]=E/W {R,Y,G}, 1=lamp on.

Function
REQ-010 The controller SHALL be a 6-state FSM: NS_G, NS_Y, RED1, EW_G, EW_Y, RED2, visited strictly in that cyclic order.
REQ-011 lights_out SHALL be: NS_G=001100, NS_Y=010100, RED1=100100, EW_G=100001, EW_Y=100010, RED2=100100.
REQ-012 Each 3-bit group SHALL always be one-hot; both groups SHALL never be non-red at the same time.
REQ-013 car_detected SHALL pass through a 2-flop synchronizer before use.
REQ-014 A request flag SHALL set on any cycle the synchronized input is 1, SHALL hold until cleared, and SHALL clear on the edge entering EW_G (a set on that same edge is lost).
REQ-015 A state timer SHALL clear on every state entry and count clock cycles in the current state; width SHALL cover the largest duration times CYCLES_PER_TICK.
REQ-016 NS_Y, RED1, EW_G, EW_Y, RED2 SHALL each last exactly duration*CYCLES_PER_TICK cycles, then advance.
REQ-017 NS_G SHALL advance to NS_Y on the first edge where at least NS_MIN_GREEN*CYCLES_PER_TICK cycles have elapsed and the request flag is 1; otherwise it SHALL remain indefinitely.
REQ-018 Detection pulses of any length (>= 1 cycle after synchronization) SHALL be serviced, including pulses during NS_Y, RED1, EW_Y, RED2.
REQ-019 A continuously held car_detected SHALL re-request after EW_G, but N/S SHALL still receive the full minimum green before the next E/W service.
REQ-020 lights_out SHALL change on the same edge as the state register (no extra latency).

Reset
REQ-021 reset_n low SHALL immediately force state NS_G, timer 0, request 0, synchronizer flops 0, lights_out 001100, independent of clock.
REQ-022 Reset asserted mid-cycle in any state SHALL abort that cycle; after release, operation SHALL restart from NS_G with full minimum green.
REQ-023 The first rising clock edge after reset_n rises SHALL begin counting.

Verification (CYCLES_PER_TICK=1, NS_MIN_GREEN=20, YELLOW=4, ALL_RED=2, EW_GREEN=10)
REQ-024 Reset, car_detected=0 for 100 cycles -> lights_out 001100 throughout.
REQ-025 car_detected held 1 from cycle 5 -> 001100 for 20 cycles, 010100 x4, 100100 x2, 100001 x10, 100010 x4, 100100 x2, then 001100 for 20 cycles, then the cycle repeats.
REQ-026 1-cycle car_detected pulse at cycle 3 -> same sequence as REQ-025, starting after 20 cycles.
REQ-027 Pulse at cycle 50 (NS_G elapsed >= 20) -> NS_Y entered 3 cycles later (2 sync + 1 flag register).
REQ-028 reset_n pulsed low during EW_G -> lights_out 001100 asynchronously, no yellow phase.
REQ-029 Every cycle of every test -> one-hot per group, never both directions non-red.

Source files
------------

// File: rtl/intxn_ctrl.sv
// Two-way intersection light controller: N/S holds green until an E/W vehicle
// request arrives and the minimum green has elapsed, then cycles through E/W service.
module intxn_ctrl #(
   parameter int unsigned CYCLES_PER_TICK = 32'd50000,
   parameter int unsigned NS_MIN_GREEN    = 32'd10000,
   parameter int unsigned YELLOW          = 32'd3000,
   parameter int unsigned ALL_RED         = 32'd1000,
   parameter int unsigned EW_GREEN        = 32'd5000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       car_detected,
   output logic [5:0] lights_out
);

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      RED1 = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      RED2 = 3'd5
   } state_t;

   localparam int unsigned NS_CYC  = NS_MIN_GREEN * CYCLES_PER_TICK;
   localparam int unsigned Y_CYC   = YELLOW * CYCLES_PER_TICK;
   localparam int unsigned AR_CYC  = ALL_RED * CYCLES_PER_TICK;
   localparam int unsigned EW_CYC  = EW_GREEN * CYCLES_PER_TICK;
   localparam int unsigned MAX_A   = (NS_CYC > Y_CYC) ? NS_CYC : Y_CYC;
   localparam int unsigned MAX_B   = (AR_CYC > EW_CYC) ? AR_CYC : EW_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int          TW      = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 1;

   // Timer holds 0..D-1 while in a state; the state advances when it reaches D-1.
   localparam logic [TW-1:0] NS_LAST = TW'(NS_CYC - 32'd1);
   localparam logic [TW-1:0] Y_LAST  = TW'(Y_CYC - 32'd1);
   localparam logic [TW-1:0] AR_LAST = TW'(AR_CYC - 32'd1);
   localparam logic [TW-1:0] EW_LAST = TW'(EW_CYC - 32'd1);

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic            r_req;
   logic            r_sync1;
   logic            r_sync2;

   state_t          w_next;
   logic            w_last;
   logic            w_advance;
   logic [TW-1:0]   w_timer_nxt;

   function automatic logic [5:0] lamp_enc(input state_t s);
      logic [5:0] l;
      case (s)
         NS_G:    l = 6'b001100;
         NS_Y:    l = 6'b010100;
         RED1:    l = 6'b100100;
         EW_G:    l = 6'b100001;
         EW_Y:    l = 6'b100010;
         RED2:    l = 6'b100100;
         default: l = 6'b100100;
      endcase
      return l;
   endfunction

   // Two-flop synchronizer for the asynchronous vehicle sensor
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= car_detected;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state decision for the current state
   always_comb begin
      w_next    = NS_G;
      w_last    = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         NS_G: begin
            w_last    = (r_timer == NS_LAST);
            w_advance = w_last & r_req;
            w_next    = NS_Y;
         end
         NS_Y: begin
            w_last    = (r_timer == Y_LAST);
            w_advance = w_last;
            w_next    = RED1;
         end
         RED1: begin
            w_last    = (r_timer == AR_LAST);
            w_advance = w_last;
            w_next    = EW_G;
         end
         EW_G: begin
            w_last    = (r_timer == EW_LAST);
            w_advance = w_last;
            w_next    = EW_Y;
         end
         EW_Y: begin
            w_last    = (r_timer == Y_LAST);
            w_advance = w_last;
            w_next    = RED2;
         end
         RED2: begin
            w_last    = (r_timer == AR_LAST);
            w_advance = w_last;
            w_next    = NS_G;
         end
         default: begin
            w_last    = 1'b1;
            w_advance = 1'b1;
            w_next    = NS_G;
         end
      endcase
   end

   // Timer saturates in NS_G so an unrequested green can last indefinitely
   always_comb begin
      w_timer_nxt = r_timer;
      if (w_advance) begin
         w_timer_nxt = '0;
      end else if (w_last) begin
         w_timer_nxt = r_timer;
      end else begin
         w_timer_nxt = r_timer + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // Main FSM: state, timer, request flag and registered lamp drive
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= NS_G;
         r_timer    <= '0;
         r_req      <= 1'b0;
         lights_out <= 6'b001100;
      end else begin
         r_timer <= w_timer_nxt;
         if (w_advance) begin
            r_state    <= w_next;
            lights_out <= lamp_enc(w_next);
         end else begin
            r_state    <= r_state;
            lights_out <= lamp_enc(r_state);
         end
         // Clearing on EW_G entry wins over a simultaneous new request
         if (w_advance && (r_state == RED1)) begin
            r_req <= 1'b0;
         end else if (r_sync2) begin
            r_req <= 1'b1;
         end else begin
            r_req <= r_req;
         end
      end
   end

endmodule

// File: tb/tb_intxn_ctrl.sv
// Directed, table-driven bench for intxn_ctrl with short timing parameters.
module tb_intxn_ctrl;

   localparam logic [5:0] L_NSG = 6'b001100;
   localparam logic [5:0] L_NSY = 6'b010100;
   localparam logic [5:0] L_RED = 6'b100100;
   localparam logic [5:0] L_EWG = 6'b100001;
   localparam logic [5:0] L_EWY = 6'b100010;

   typedef struct {
      logic       car;
      int         n;
      logic [5:0] exp;
   } vec_t;

   logic       clock        = 1'b0;
   logic       reset_n      = 1'b0;
   logic       car_detected = 1'b0;
   logic [5:0] lights_out;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl[$];

   always #5 clock = ~clock;

   intxn_ctrl #(
      .CYCLES_PER_TICK(32'd1),
      .NS_MIN_GREEN   (32'd20),
      .YELLOW         (32'd4),
      .ALL_RED        (32'd2),
      .EW_GREEN       (32'd10)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .car_detected(car_detected),
      .lights_out  (lights_out)
   );

   task automatic check(input string name, input logic [5:0] exp);
      n_checks++;
      if (lights_out !== exp) begin
         n_fail++;
         $display("FAIL %s: lights_out=%b expected=%b at %0t", name, lights_out, exp, $time);
      end
   endtask

   task automatic check_safe(input string name);
      logic [2:0] ns;
      logic [2:0] ew;
      ns = lights_out[5:3];
      ew = lights_out[2:0];
      n_checks++;
      if (!$onehot(ns) || !$onehot(ew) || ((ns != 3'b100) && (ew != 3'b100))) begin
         n_fail++;
         $display("FAIL %s_safety: lights_out=%b expected one-hot groups with one side red at %0t",
                  name, lights_out, $time);
      end
   endtask

   function automatic void add(input logic c, input int n, input logic [5:0] e);
      vec_t v;
      v.car = c;
      v.n   = n;
      v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic do_reset(input string name);
      reset_n      = 1'b0;
      car_detected = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check({name, "_reset"}, L_NSG);
      check_safe(name);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic run_tbl(input string name);
      for (int r = 0; r < tbl.size(); r++) begin
         for (int k = 0; k < tbl[r].n; k++) begin
            car_detected = tbl[r].car;
            @(posedge clock);
            #1;
            check(name, tbl[r].exp);
            check_safe(name);
         end
      end
      tbl.delete();
   endtask

   initial begin
      // Idle: no request keeps N/S green
      do_reset("idle");
      add(1'b0, 100, L_NSG);
      run_tbl("idle");

      // Held request from cycle 5, two full rounds
      do_reset("held");
      add(1'b0, 4, L_NSG);  add(1'b1, 15, L_NSG); add(1'b1, 4, L_NSY);
      add(1'b1, 2, L_RED);  add(1'b1, 10, L_EWG); add(1'b1, 4, L_EWY);
      add(1'b1, 2, L_RED);  add(1'b1, 20, L_NSG); add(1'b1, 4, L_NSY);
      add(1'b1, 2, L_RED);  add(1'b1, 10, L_EWG);
      run_tbl("held");

      // Single-cycle pulse at cycle 3, then no further service
      do_reset("pulse3");
      add(1'b0, 2, L_NSG);  add(1'b1, 1, L_NSG);  add(1'b0, 16, L_NSG);
      add(1'b0, 4, L_NSY);  add(1'b0, 2, L_RED);  add(1'b0, 10, L_EWG);
      add(1'b0, 4, L_EWY);  add(1'b0, 2, L_RED);  add(1'b0, 30, L_NSG);
      run_tbl("pulse3");

      // Late pulse after min green: NS_Y three cycles after first sync capture
      do_reset("late");
      add(1'b0, 49, L_NSG); add(1'b1, 1, L_NSG);  add(1'b0, 2, L_NSG);
      add(1'b0, 4, L_NSY);  add(1'b0, 2, L_RED);  add(1'b0, 10, L_EWG);
      run_tbl("late");

      // Pulse during EW_Y is serviced after a full min green
      do_reset("ewy_pulse");
      add(1'b0, 2, L_NSG);  add(1'b1, 1, L_NSG);  add(1'b0, 16, L_NSG);
      add(1'b0, 4, L_NSY);  add(1'b0, 2, L_RED);  add(1'b0, 10, L_EWG);
      add(1'b0, 1, L_EWY);  add(1'b1, 1, L_EWY);  add(1'b0, 2, L_EWY);
      add(1'b0, 2, L_RED);  add(1'b0, 20, L_NSG); add(1'b0, 4, L_NSY);
      run_tbl("ewy_pulse");

      // Request reaching the flag on the EW_G entry edge is lost
      do_reset("lost");
      add(1'b0, 2, L_NSG);  add(1'b1, 1, L_NSG);  add(1'b0, 16, L_NSG);
      add(1'b0, 4, L_NSY);  add(1'b1, 1, L_RED);  add(1'b0, 1, L_RED);
      add(1'b0, 10, L_EWG); add(1'b0, 4, L_EWY);  add(1'b0, 2, L_RED);
      add(1'b0, 30, L_NSG);
      run_tbl("lost");

      // One cycle later the request lands during EW_G and is kept
      do_reset("kept");
      add(1'b0, 2, L_NSG);  add(1'b1, 1, L_NSG);  add(1'b0, 16, L_NSG);
      add(1'b0, 4, L_NSY);  add(1'b0, 1, L_RED);  add(1'b1, 1, L_RED);
      add(1'b0, 10, L_EWG); add(1'b0, 4, L_EWY);  add(1'b0, 2, L_RED);
      add(1'b0, 20, L_NSG); add(1'b0, 4, L_NSY);
      run_tbl("kept");

      // Reset asserted mid-cycle during EW_G
      do_reset("midrst");
      add(1'b1, 19, L_NSG); add(1'b1, 4, L_NSY);  add(1'b1, 2, L_RED);
      add(1'b1, 5, L_EWG);
      run_tbl("midrst");
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", L_NSG);
      check_safe("async_reset");
      @(posedge clock);
      #1;
      check("reset_held", L_NSG);
      @(negedge clock);
      reset_n = 1'b1;
      add(1'b1, 19, L_NSG); add(1'b1, 4, L_NSY);  add(1'b1, 2, L_RED);
      run_tbl("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
